hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the vector processor: drives stall_F/stall_D/stall_E and flush_D/flush_E
//  into the fetch/decode and decode/execute pipeline registers, and selects E-stage operand forwarding.
//  Sequences multi-beat vector memory ops (128-bit register moved as LANES x 32-bit beats) by holding E.
//  Also covers load-use stalls and taken-branch flushes. Sits beside the pipeline registers in the top-level processor.
// PARAMETERS
//  LANES   4  32-bit beats per vector memory op (128/32); must be >=2
//  REG_W   4  register address width (16 scalar + 16 vector registers)
// PORTS
//  clk             in   1      clock; all state updates on rising edge
//  rst             in   1      synchronous, active-high reset
//  rs1_D, rs2_D    in   REG_W  source register addresses of instruction in D
//  vect_D          in   1      D instruction uses vector register file
//  rs1_E, rs2_E    in   REG_W  source register addresses of instruction in E
//  rd_E            in   REG_W  destination register of instruction in E
//  vect_E          in   1      E instruction is vector
//  regmem_E        in   1      E instruction is a load (result from memory)
//  memw_E          in   1      E instruction is a store
//  regw_M, vect_M  in   1      M stage writes a register / that register is vector
//  rd_M            in   REG_W  destination register of M stage
//  regw_W, vect_W  in   1      W stage writes a register / that register is vector
//  rd_W            in   REG_W  destination register of W stage
//  branch_taken_E  in   1      branch resolved taken in E this cycle
//  stall_F, stall_D, stall_E   out 1  hold PC / D register / E register
//  flush_D, flush_E            out 1  clear D / E register to bubble
//  fwdA_E, fwdB_E  out  2      operand select: 00 register file, 01 from W, 10 from M
//  vbeat           out  $clog2(LANES)  current beat index of vector memory op in E
//  vmem_busy       out  1      FSM in VMEM state
// BEHAVIOUR
//  Reset: state IDLE, beat counter 0. All outputs 0 in the reset cycle, overriding every combinational term.
//  Scalar register 0 is constant zero: an address-0 match with vect=0 never forwards and never stalls.
//  Register match requires equal address AND equal vect flag (separate scalar/vector files).
//  Forwarding: fwdA_E=10 if regw_M & rd_M==rs1_E & vect_M==vect_E; else 01 if same test on W; else 00.
//   M has priority over W. Same rule for fwdB_E with rs2_E.
//  vmem_E = vect_E & (regmem_E | memw_E).
//  FSM IDLE: vbeat=0.
//   If vmem_E, assert stall_F, stall_D, stall_E; next state VMEM, beat<=1.
//  FSM VMEM: vbeat=beat, vmem_busy=1.
//   If beat!=LANES-1, assert all three stalls and beat<=beat+1.
//   If beat==LANES-1, release vmem stalls; next state IDLE, beat<=0.
//   The E op therefore occupies E for exactly LANES cycles (beats 0..LANES-1).
//  Load-use: regmem_E & regw-type dest rd_E matches rs1_D or rs2_D (with vect_E==vect_D) ->
//   assert stall_F, stall_D, flush_E for one cycle. The op then forwards from W.
//  Branch: branch_taken_E -> flush_D=1, flush_E=1. No vmem op can be in E simultaneously.
//  Priority / simultaneous events:
//   1. rst.
//   2. branch_taken_E: flushes win, and F/D stalls are forced 0.
//   3. vmem stall: stall_E=1 suppresses flush_E.
//   4. load-use.
//   Final vmem beat of a vector load with a dependent op in D: stall_E=0, stall_F=stall_D=1, flush_E=1.
//  Reset mid-VMEM: FSM returns to IDLE and beat to 0 on that edge; there is no partial resume.
//  Stall/flush outputs are combinational from current inputs + state. Forwarding adds zero latency.
// STRUCTURE
//  Package vproc_hazard_pkg holds:
//   - typedef enum logic {S_IDLE, S_VMEM} hz_state_t
//   - constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
//   - LANES default
//  Sub-module vmem_beat_fsm (state + beat counter, outputs vmem_stall, vbeat, vmem_busy).
//  Forwarding and load-use logic stay in hazard_ctrl.
// TESTING
//  1. rst=1 with vmem_E=1 and branch_taken_E=1 -> every output 0; next cycle, rst=0, vmem starts at vbeat=0.
//  2. Vector load in E (vect_E=1, regmem_E=1), no dependents -> stall_E=1 at vbeat 0,1,2; stall_E=0 at
//     vbeat 3; vmem_busy high 3 cycles; IDLE after.
//  3. Scalar load rd_E=3; D uses rs1_D=3 (vect 0) -> one cycle stall_F=stall_D=flush_E=1; next cycle
//     rs1_E=3, rd_W=3, regw_W=1 -> fwdA_E=01.
//  4. regw_M=1, rd_M=5 and regw_W=1, rd_W=5, rs2_E=5, all scalar -> fwdB_E=10.
//     Repeat with vect_M=1 -> fwdB_E=01. rs2_E=0 scalar with rd_M=0 -> fwdB_E=00.
//  5. branch_taken_E=1 during load-use condition -> flush_D=flush_E=1, stall_F=stall_D=0.
//  6. rst asserted at vbeat=2 of vector store -> next cycle IDLE, vbeat=0, stalls 0 if E cleared.

Source files
------------

// File: rtl/vproc_hazard_pkg.sv
// ============================================================================
//  Module      : vproc_hazard_pkg
//  Description : Shared types and constants for the vector-processor hazard
//                controller (FSM states, forwarding selects, defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vproc_hazard_pkg;

  typedef enum logic {S_IDLE, S_VMEM} hz_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int LANES_DEFAULT = 4;
  localparam int REG_W_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/vmem_beat_fsm.sv
// ============================================================================
//  Module      : vmem_beat_fsm
//  Description : Beat sequencer for multi-beat vector memory ops held in E.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vmem_beat_fsm
  import vproc_hazard_pkg::*;
#(
  parameter int LANES  = LANES_DEFAULT,
  parameter int BEAT_W = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vmem_start,
  output logic              o_vmem_stall,
  output logic [BEAT_W-1:0] o_vbeat,
  output logic              o_vmem_busy
);

  localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(LANES - 1);

  hz_state_t         r_state;
  hz_state_t         w_state_nxt;
  logic [BEAT_W-1:0] r_beat;
  logic [BEAT_W-1:0] w_beat_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Beat 0 is spent in IDLE, so VMEM only covers beats 1..LANES-1.
  always_comb begin
    w_state_nxt  = r_state;
    w_beat_nxt   = r_beat;
    o_vmem_stall = 1'b0;
    o_vbeat      = '0;
    o_vmem_busy  = 1'b0;
    case (r_state)
      S_VMEM: begin
        o_vbeat     = r_beat;
        o_vmem_busy = 1'b1;
        if (r_beat != c_LAST_BEAT) begin
          o_vmem_stall = 1'b1;
          w_beat_nxt   = r_beat + BEAT_W'(1);
        end else begin
          w_state_nxt = S_IDLE;
          w_beat_nxt  = '0;
        end
      end
      default: begin
        if (i_vmem_start) begin
          o_vmem_stall = 1'b1;
          w_state_nxt  = S_VMEM;
          w_beat_nxt   = BEAT_W'(1);
        end
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Stall/flush and E-stage forwarding control for the vector
//                processor pipeline, including multi-beat vector memory ops.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import vproc_hazard_pkg::*;
#(
  parameter int LANES = LANES_DEFAULT,
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_W-1:0]         rs1_D,
  input  logic [REG_W-1:0]         rs2_D,
  input  logic                     vect_D,
  input  logic [REG_W-1:0]         rs1_E,
  input  logic [REG_W-1:0]         rs2_E,
  input  logic [REG_W-1:0]         rd_E,
  input  logic                     vect_E,
  input  logic                     regmem_E,
  input  logic                     memw_E,
  input  logic                     regw_M,
  input  logic                     vect_M,
  input  logic [REG_W-1:0]         rd_M,
  input  logic                     regw_W,
  input  logic                     vect_W,
  input  logic [REG_W-1:0]         rd_W,
  input  logic                     branch_taken_E,
  output logic                     stall_F,
  output logic                     stall_D,
  output logic                     stall_E,
  output logic                     flush_D,
  output logic                     flush_E,
  output logic [1:0]               fwdA_E,
  output logic [1:0]               fwdB_E,
  output logic [$clog2(LANES)-1:0] vbeat,
  output logic                     vmem_busy
);

  localparam int BEAT_W = $clog2(LANES);

  // Scalar r0 is hard-wired zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] a, input logic va,
                                     input logic [REG_W-1:0] b, input logic vb);
    return (a == b) && (va == vb) && !((a == '0) && !va);
  endfunction

  logic              w_vmem_E;
  logic              w_vmem_stall;
  logic [BEAT_W-1:0] w_vbeat;
  logic              w_vmem_busy;
  logic              w_load_use;
  logic [1:0]        w_fwdA;
  logic [1:0]        w_fwdB;

  assign w_vmem_E = vect_E & (regmem_E | memw_E);

  vmem_beat_fsm #(
    .LANES  (LANES),
    .BEAT_W (BEAT_W)
  ) u_vmem_beat_fsm (
    .clk          (clk),
    .rst          (rst),
    .i_vmem_start (w_vmem_E),
    .o_vmem_stall (w_vmem_stall),
    .o_vbeat      (w_vbeat),
    .o_vmem_busy  (w_vmem_busy)
  );

  assign w_load_use = regmem_E & (reg_match(rd_E, vect_E, rs1_D, vect_D) |
                                  reg_match(rd_E, vect_E, rs2_D, vect_D));

  always_comb begin
    w_fwdA = FWD_RF;
    if (regw_M && reg_match(rd_M, vect_M, rs1_E, vect_E))      w_fwdA = FWD_M;
    else if (regw_W && reg_match(rd_W, vect_W, rs1_E, vect_E)) w_fwdA = FWD_W;
    w_fwdB = FWD_RF;
    if (regw_M && reg_match(rd_M, vect_M, rs2_E, vect_E))      w_fwdB = FWD_M;
    else if (regw_W && reg_match(rd_W, vect_W, rs2_E, vect_E)) w_fwdB = FWD_W;
  end

  // Priority: reset, then taken branch, then vmem hold, then load-use.
  always_comb begin
    stall_F   = 1'b0;
    stall_D   = 1'b0;
    stall_E   = 1'b0;
    flush_D   = 1'b0;
    flush_E   = 1'b0;
    fwdA_E    = FWD_RF;
    fwdB_E    = FWD_RF;
    vbeat     = '0;
    vmem_busy = 1'b0;
    if (!rst) begin
      fwdA_E    = w_fwdA;
      fwdB_E    = w_fwdB;
      vbeat     = w_vbeat;
      vmem_busy = w_vmem_busy;
      if (branch_taken_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else begin
        stall_E = w_vmem_stall;
        stall_F = w_vmem_stall | w_load_use;
        stall_D = w_vmem_stall | w_load_use;
        flush_E = w_load_use & ~w_vmem_stall;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Scoreboard bench for hazard_ctrl with directed and random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int LANES = 4;

  typedef struct {
    bit       rst;
    bit [3:0] rs1_D, rs2_D;
    bit       vect_D;
    bit [3:0] rs1_E, rs2_E, rd_E;
    bit       vect_E, regmem_E, memw_E;
    bit       regw_M, vect_M;
    bit [3:0] rd_M;
    bit       regw_W, vect_W;
    bit [3:0] rd_W;
    bit       br;
  } stim_t;

  typedef struct packed {
    logic       sF, sD, sE, fD, fE;
    logic [1:0] fa, fb, vb;
    logic       busy;
  } resp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rs1_D = '0, rs2_D = '0, rs1_E = '0, rs2_E = '0, rd_E = '0, rd_M = '0, rd_W = '0;
  logic       vect_D = 0, vect_E = 0, regmem_E = 0, memw_E = 0;
  logic       regw_M = 0, vect_M = 0, regw_W = 0, vect_W = 0, branch_taken_E = 0;
  logic       stall_F, stall_D, stall_E, flush_D, flush_E, vmem_busy;
  logic [1:0] fwdA_E, fwdB_E, vbeat;

  always #5 clk = ~clk;

  hazard_ctrl #(.LANES(LANES), .REG_W(4)) dut (
    .clk(clk), .rst(rst),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .vect_D(vect_D),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .vect_E(vect_E),
    .regmem_E(regmem_E), .memw_E(memw_E),
    .regw_M(regw_M), .vect_M(vect_M), .rd_M(rd_M),
    .regw_W(regw_W), .vect_W(vect_W), .rd_W(rd_W),
    .branch_taken_E(branch_taken_E),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
    .flush_D(flush_D), .flush_E(flush_E),
    .fwdA_E(fwdA_E), .fwdB_E(fwdB_E), .vbeat(vbeat), .vmem_busy(vmem_busy)
  );

  resp_t q_exp[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    m_pos = 0;   // cycles the current vector memory op has already spent in E
  resp_t last_exp;

  function automatic bit hit(bit [3:0] a, bit va, bit [3:0] b, bit vb);
    if (a == 0 && !va) return 0;
    return (a == b) && (va == vb);
  endfunction

  function automatic bit [1:0] fwd_sel(stim_t s, bit [3:0] rs);
    if (s.regw_M && hit(s.rd_M, s.vect_M, rs, s.vect_E)) return 2'd2;
    if (s.regw_W && hit(s.rd_W, s.vect_W, rs, s.vect_E)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic stim_t zs();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    resp_t e;
    bit    vm, vstall, lu;
    @(posedge clk);
    #1;
    rst = s.rst; rs1_D = s.rs1_D; rs2_D = s.rs2_D; vect_D = s.vect_D;
    rs1_E = s.rs1_E; rs2_E = s.rs2_E; rd_E = s.rd_E; vect_E = s.vect_E;
    regmem_E = s.regmem_E; memw_E = s.memw_E;
    regw_M = s.regw_M; vect_M = s.vect_M; rd_M = s.rd_M;
    regw_W = s.regw_W; vect_W = s.vect_W; rd_W = s.rd_W;
    branch_taken_E = s.br;
    e  = '0;
    vm = s.vect_E && (s.regmem_E || s.memw_E);
    if (!s.rst) begin
      vstall = (m_pos == 0) ? vm : (m_pos < LANES - 1);
      lu = s.regmem_E && (hit(s.rd_E, s.vect_E, s.rs1_D, s.vect_D) ||
                          hit(s.rd_E, s.vect_E, s.rs2_D, s.vect_D));
      if (s.br) begin
        e.fD = 1; e.fE = 1;
      end else begin
        e.sE = vstall;
        e.sF = vstall | lu;
        e.sD = vstall | lu;
        e.fE = lu & ~vstall;
      end
      e.fa   = fwd_sel(s, s.rs1_E);
      e.fb   = fwd_sel(s, s.rs2_E);
      e.vb   = 2'(m_pos);
      e.busy = (m_pos != 0);
    end
    q_exp.push_back(e);
    last_exp = e;
    if (s.rst)           m_pos = 0;
    else if (m_pos != 0) m_pos = (m_pos + 1) % LANES;
    else if (vm)         m_pos = 1;
  endtask

  initial begin : monitor
    resp_t e, got;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        e   = q_exp.pop_front();
        got = '{stall_F, stall_D, stall_E, flush_D, flush_E, fwdA_E, fwdB_E, vbeat, vmem_busy};
        n_vec++;
        if (got !== e) begin
          n_err++;
          $display("FAIL vec%0d {sF,sD,sE,fD,fE,fwdA,fwdB,vbeat,busy}: got %b expected %b",
                   n_vec, got, e);
        end
      end
    end
  end

  initial begin : stim
    stim_t s, cur;
    // reset overrides vmem start and branch, then a vector load runs its 4 beats
    s = zs(); s.rst = 1; s.vect_E = 1; s.regmem_E = 1; s.rd_E = 4'd2; s.br = 1;
    apply(s);
    s.rst = 0; s.br = 0;
    for (int i = 0; i < LANES; i++) apply(s);
    apply(zs());
    // scalar load-use then forward from W
    s = zs(); s.regmem_E = 1; s.rd_E = 4'd3; s.rs1_D = 4'd3;
    apply(s);
    s = zs(); s.rs1_E = 4'd3; s.rd_W = 4'd3; s.regw_W = 1;
    apply(s);
    // M over W priority, vect mismatch, scalar r0
    s = zs(); s.regw_M = 1; s.rd_M = 4'd5; s.regw_W = 1; s.rd_W = 4'd5; s.rs2_E = 4'd5;
    apply(s);
    s.vect_M = 1;
    apply(s);
    s.vect_M = 0; s.rd_M = 4'd0; s.rs2_E = 4'd0; s.rs1_E = 4'd0;
    apply(s);
    // branch beats load-use
    s = zs(); s.regmem_E = 1; s.rd_E = 4'd7; s.rs2_D = 4'd7; s.br = 1;
    apply(s);
    // vector load whose last beat meets a dependent D op
    s = zs(); s.vect_E = 1; s.regmem_E = 1; s.rd_E = 4'd6; s.vect_D = 1; s.rs1_D = 4'd6;
    for (int i = 0; i < LANES; i++) apply(s);
    apply(zs());
    // reset in the middle of a vector store
    s = zs(); s.vect_E = 1; s.memw_E = 1; s.rd_E = 4'd1;
    for (int i = 0; i < 3; i++) apply(s);
    s.rst = 1;
    apply(s);
    apply(zs());
    apply(zs());
    // random traffic; E fields are held while E is stalled
    cur = zs();
    for (int n = 0; n < 400; n++) begin
      s = zs();
      s.rs1_D  = 4'($urandom_range(0, 3)); s.rs2_D = 4'($urandom_range(0, 3));
      s.vect_D = 1'($urandom_range(0, 1));
      s.regw_M = 1'($urandom_range(0, 1)); s.vect_M = 1'($urandom_range(0, 1));
      s.rd_M   = 4'($urandom_range(0, 3));
      s.regw_W = 1'($urandom_range(0, 1)); s.vect_W = 1'($urandom_range(0, 1));
      s.rd_W   = 4'($urandom_range(0, 3));
      if (last_exp.sE) begin
        s.rs1_E = cur.rs1_E; s.rs2_E = cur.rs2_E; s.rd_E = cur.rd_E;
        s.vect_E = cur.vect_E; s.regmem_E = cur.regmem_E; s.memw_E = cur.memw_E;
      end else begin
        s.rs1_E  = 4'($urandom_range(0, 3)); s.rs2_E = 4'($urandom_range(0, 3));
        s.rd_E   = 4'($urandom_range(0, 3));
        s.vect_E = 1'($urandom_range(0, 1));
        s.regmem_E = ($urandom_range(0, 2) == 0);
        s.memw_E   = !s.regmem_E && ($urandom_range(0, 3) == 0);
      end
      if (m_pos == 0 && !(s.vect_E && (s.regmem_E || s.memw_E)))
        s.br = ($urandom_range(0, 7) == 0);
      s.rst = ($urandom_range(0, 39) == 0);
      cur = s;
      apply(s);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (q_exp.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d responses left unchecked, required 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
